uart_rx: RTL and testbench

8N1 UART receiver, the downstream partner of the team's uart_tx. It deserialises the serial line `data_out` produced by uart_tx, LSB first, and presents each byte with a one-cycle valid strobe. Incoming bits are sampled at mid-bit using the same CLKS_PER_BIT timing as the transmitter. Stop-bit violations are reported as framing errors.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 33 +++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// The state encoding is common to anything that observes the receiver FSM.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Offset of the mid-bit sample point, counted from the detected start edge
  function automatic int half_bit(input int clks);
    return (clks - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous inputs. The reset value is chosen
// per use, so an idle-high line does not look active coming out of reset.
module uart_sync #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gen_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= RESET_VAL;
          sync_reg <= RESET_VAL;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_out[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle valid and
// framing-error strobes. It leaves a frame halfway through the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] byte_recv,
  output logic       data_valid,
  output logic       recv_active,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_state_t               state_reg;
  logic [CNT_W-1:0]          clk_cnt_reg;
  logic [2:0]                bit_idx_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [7:0]                byte_reg;
  logic                      valid_reg;
  logic                      active_reg;
  logic                      ferr_reg;

  uart_sync #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(data_in),
    .sync_out(rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      byte_reg    <= '0;
      valid_reg   <= 1'b0;
      active_reg  <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          active_reg  <= 1'b0;
          clk_cnt_reg <= '0;
          if (!rx_s) begin
            state_reg  <= START;
            active_reg <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt_reg == HALF_CNT) begin
            clk_cnt_reg <= '0;
            if (!rx_s) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end else begin
              // Start bit vanished before mid-bit: treat it as a glitch
              state_reg  <= IDLE;
              active_reg <= 1'b0;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt_reg == LAST_CNT) begin
            clk_cnt_reg            <= '0;
            shift_reg[bit_idx_reg] <= rx_s;
            if (bit_idx_reg == LAST_BIT) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt_reg == LAST_CNT) begin
            clk_cnt_reg <= '0;
            if (rx_s) begin
              byte_reg   <= shift_reg;
              valid_reg  <= 1'b1;
              state_reg  <= IDLE;
              active_reg <= 1'b0;
            end else begin
              ferr_reg  <= 1'b1;
              state_reg <= WAIT_HIGH;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        // A break or stuck-low line must return high before the next start
        WAIT_HIGH: begin
          if (rx_s) begin
            state_reg  <= IDLE;
            active_reg <= 1'b0;
          end
        end

        default: begin
          state_reg  <= IDLE;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign byte_recv   = byte_reg;
  assign data_valid  = valid_reg;
  assign recv_active = active_reg;
  assign frame_err   = ferr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural 8N1 transmitter drives the
// line, expected bytes go into a queue and are popped on each data_valid.
module tb_uart_rx;

  localparam int CLKS = 87;
  localparam int HALF = (CLKS - 1) / 2;

  logic       clk;
  logic       rst;
  logic       data_in;
  logic [7:0] byte_recv;
  logic       data_valid;
  logic       recv_active;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int ovl_cnt = 0;
  int dv_cyc = 0;
  int start_cyc = 0;
  logic abort = 1'b0;
  logic [7:0] model_byte = 8'h00;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .byte_recv  (byte_recv),
    .data_valid (data_valid),
    .recv_active(recv_active),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every data_valid pops one expected byte
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && frame_err) ovl_cnt++;
      if (frame_err) begin
        fe_cnt++;
        $display("[%0d] frame_err", cyc);
      end
      if (data_valid) begin
        logic [7:0] exp_b;
        dv_cnt++;
        dv_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: byte_recv=%02h, no byte expected", byte_recv);
        end else begin
          exp_b = exp_q.pop_front();
          if (byte_recv !== exp_b) begin
            bad++;
            $display("FAIL rx_byte: got %02h expected %02h", byte_recv, exp_b);
          end else begin
            $display("[%0d] rx byte=%02h ok", cyc, byte_recv);
          end
          model_byte = exp_b;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller must be at posedge+1; returns at posedge+1 after the stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      data_in = bits[i];
      if (i == 0) start_cyc = cyc;
      for (int c = 0; c < CLKS; c++) begin
        tick();
        if (abort) begin
          data_in = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 1'b1;
    repeat (3) tick();
    total++;
    if ({byte_recv, data_valid, recv_active, frame_err} !== 11'h000) begin
      bad++;
      $display("FAIL reset_outputs: got byte=%02h dv=%b act=%b fe=%b required 00/0/0/0",
               byte_recv, data_valid, recv_active, frame_err);
    end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_loopback();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int lat;
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1);
    repeat (50) tick();
    lat = dv_cyc - start_cyc;
    total++;
    if (dv_cnt - dv0 != 1) begin
      bad++;
      $display("FAIL loopback_pulses: got %0d required 1", dv_cnt - dv0);
    end
    total++;
    if (lat < 827 || lat > 831) begin
      bad++;
      $display("FAIL loopback_latency: got %0d required 829+-2", lat);
    end
    total++;
    if (fe_cnt != fe0) begin
      bad++;
      $display("FAIL loopback_ferr: got %0d pulses required 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back();
    int dv0 = dv_cnt;
    int gap = 0;
    int waited = 0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        while (dv_cnt == dv0 && waited < 2000) begin
          tick();
          waited++;
        end
        while (!recv_active && gap < 500) begin
          tick();
          gap++;
        end
      end
    join
    repeat (50) tick();
    total++;
    if (waited >= 2000) begin
      bad++;
      $display("FAIL b2b_timeout: first valid not seen in %0d cycles", waited);
    end
    total++;
    if (dv_cnt - dv0 != 2) begin
      bad++;
      $display("FAIL b2b_pulses: got %0d required 2", dv_cnt - dv0);
    end
    total++;
    if (gap == 0 || gap >= CLKS) begin
      bad++;
      $display("FAIL b2b_idle_gap: got %0d cycles required 1..%0d", gap, CLKS - 1);
    end
    total++;
    if (byte_recv !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_last_byte: got %02h required ff", byte_recv);
    end
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int run = 0;
    int max_run = 0;
    data_in = 1'b0;
    for (int i = 0; i < 220; i++) begin
      if (i == 20) data_in = 1'b1;
      tick();
      if (recv_active) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    total++;
    if (max_run == 0 || max_run > HALF + 1) begin
      bad++;
      $display("FAIL glitch_active: got %0d cycles required 1..%0d", max_run, HALF + 1);
    end
    total++;
    if (dv_cnt != dv0 || fe_cnt != fe0) begin
      bad++;
      $display("FAIL glitch_pulses: got dv=%0d fe=%0d required 0/0", dv_cnt - dv0, fe_cnt - fe0);
    end
  endtask

  task automatic test_framing();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    logic [7:0] prev = model_byte;
    send_frame(8'h3C, 1'b0);
    repeat (300) tick();
    total++;
    if (fe_cnt - fe0 != 1) begin
      bad++;
      $display("FAIL ferr_pulses: got %0d required 1", fe_cnt - fe0);
    end
    total++;
    if (dv_cnt != dv0) begin
      bad++;
      $display("FAIL ferr_no_valid: got %0d pulses required 0", dv_cnt - dv0);
    end
    total++;
    if (byte_recv !== prev) begin
      bad++;
      $display("FAIL ferr_byte_hold: got %02h required %02h", byte_recv, prev);
    end
    total++;
    if (recv_active !== 1'b1) begin
      bad++;
      $display("FAIL ferr_wait_high: recv_active=%b required 1 while line low", recv_active);
    end
    data_in = 1'b1;
    repeat (20) tick();
    total++;
    if (recv_active !== 1'b0) begin
      bad++;
      $display("FAIL ferr_release: recv_active=%b required 0", recv_active);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (50) tick();
    total++;
    if (dv_cnt - dv0 != 1 || fe_cnt - fe0 != 1) begin
      bad++;
      $display("FAIL ferr_recover: got dv=%0d fe=%0d required 1/1", dv_cnt - dv0, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_midframe();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    logic was_active = 1'b0;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (5 * CLKS + 40) tick();
        was_active = recv_active;
        rst = 1'b1;
        abort = 1'b1;
        data_in = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({byte_recv, data_valid, recv_active, frame_err} !== 11'h000) begin
          bad++;
          $display("FAIL midrst_outputs: got byte=%02h dv=%b act=%b fe=%b required 00/0/0/0",
                   byte_recv, data_valid, recv_active, frame_err);
        end
        tick();
      end
    join
    abort = 1'b0;
    total++;
    if (was_active !== 1'b1) begin
      bad++;
      $display("FAIL midrst_inframe: recv_active=%b before reset required 1", was_active);
    end
    repeat (CLKS) tick();
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    repeat (50) tick();
    total++;
    if (dv_cnt - dv0 != 1 || fe_cnt != fe0) begin
      bad++;
      $display("FAIL midrst_recover: got dv=%0d fe=%0d required 1/0", dv_cnt - dv0, fe_cnt - fe0);
    end
    total++;
    if (byte_recv !== 8'h96) begin
      bad++;
      $display("FAIL midrst_byte: got %02h required 96", byte_recv);
    end
  endtask

  task automatic test_final();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: %0d bytes never received", exp_q.size());
    end
    total++;
    if (ovl_cnt != 0) begin
      bad++;
      $display("FAIL valid_ferr_overlap: got %0d cycles required 0", ovl_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_in = 1'b1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
